// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multi-cycle controller and datapath for a small register
// machine. It holds an instruction register, eight general registers (R0-R7),
// operand registers A and B, result register C and the Z/N/V status flags.
// A seven-state FSM steps each instruction through decode, operand fetch,
// ALU evaluation and register write-back.
//
// Handshake: w=1 means the FSM sits in WAIT and is ready. While w=1, a 1 on s
// at a rising edge starts the instruction held in IR. s is ignored until w
// returns to 1. If s stays high, the next instruction starts on the first
// edge spent in WAIT. load may be asserted at any time. It updates IR only.
// The running instruction keeps the fields it latched when it left DECODE.
//
// WIDTH is legal from 16 to 64. The 8-bit immediate is sign-extended to WIDTH.
module datapath_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      in,
  input  logic             load,
  input  logic             s,
  output logic             w,
  output logic [WIDTH-1:0] out,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             err
);

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_GET_A     = 3'd2,
    ST_GET_B     = 3'd3,
    ST_CALC      = 3'd4,
    ST_WRITE_REG = 3'd5,
    ST_WRITE_IMM = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_MOV_IMM = 3'd0,
    CLS_MOV_REG = 3'd1,
    CLS_ADD     = 3'd2,
    CLS_CMP     = 3'd3,
    CLS_AND     = 3'd4,
    CLS_MVN     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } cls_t;

  state_t state;
  state_t state_next;

  logic [15:0]      ir;
  logic [15:0]      cur;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] reg_c;
  logic [WIDTH-1:0] regs [8];
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;

  cls_t ir_cls;
  cls_t cur_cls;

  logic [2:0]       cur_rn;
  logic [2:0]       cur_rd;
  logic [1:0]       cur_sh;
  logic [2:0]       cur_rm;
  logic [WIDTH-1:0] imm_ext;

  logic [WIDTH-1:0] b_shift;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             diff_v;

  // Map opcode/op onto an instruction class. Any combination not listed
  // is illegal.
  function automatic cls_t decode_cls(input logic [15:0] word);
    cls_t c;
    c = CLS_ILLEGAL;
    case ({word[15:13], word[12:11]})
      5'b110_10: c = CLS_MOV_IMM;
      5'b110_00: c = CLS_MOV_REG;
      5'b101_00: c = CLS_ADD;
      5'b101_01: c = CLS_CMP;
      5'b101_10: c = CLS_AND;
      5'b101_11: c = CLS_MVN;
      default:   c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

  assign ir_cls  = decode_cls(ir);
  assign cur_cls = decode_cls(cur);
  assign cur_rn  = cur[10:8];
  assign cur_rd  = cur[7:5];
  assign cur_sh  = cur[4:3];
  assign cur_rm  = cur[2:0];
  assign imm_ext = {{(WIDTH-8){cur[7]}}, cur[7:0]};

  // State register. Reset returns to WAIT from any state and aborts the
  // current instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_WAIT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. err flags an illegal opcode during its DECODE cycle.
  always_comb begin
    state_next = state;
    err        = 1'b0;
    case (state)
      ST_WAIT: begin
        if (s) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        case (ir_cls)
          CLS_MOV_IMM:               state_next = ST_WRITE_IMM;
          CLS_MOV_REG, CLS_MVN:      state_next = ST_GET_B;
          CLS_ADD, CLS_AND, CLS_CMP: state_next = ST_GET_A;
          default: begin
            state_next = ST_WAIT;
            err        = 1'b1;
          end
        endcase
      end
      ST_GET_A:     state_next = ST_GET_B;
      ST_GET_B:     state_next = ST_CALC;
      ST_CALC:      state_next = (cur_cls == CLS_CMP) ? ST_WAIT : ST_WRITE_REG;
      ST_WRITE_REG: state_next = ST_WAIT;
      ST_WRITE_IMM: state_next = ST_WAIT;
      default:      state_next = ST_WAIT;
    endcase
  end

  // Shifter on operand B, then the ALU. MOV reg relies on A having been
  // forced to 0, so that A+B passes the shifted B through unchanged.
  always_comb begin
    b_shift = reg_b;
    case (cur_sh)
      2'b01:   b_shift = {reg_b[WIDTH-2:0], 1'b0};
      2'b10:   b_shift = {1'b0, reg_b[WIDTH-1:1]};
      2'b11:   b_shift = {reg_b[WIDTH-1], reg_b[WIDTH-1:1]};
      default: b_shift = reg_b;
    endcase
    diff   = reg_a - b_shift;
    diff_v = (reg_a[WIDTH-1] != b_shift[WIDTH-1]) &&
             (diff[WIDTH-1] != reg_a[WIDTH-1]);
    case (cur_cls)
      CLS_CMP: alu_res = diff;
      CLS_AND: alu_res = reg_a & b_shift;
      CLS_MVN: alu_res = ~b_shift;
      default: alu_res = reg_a + b_shift;
    endcase
  end

  // Datapath registers. IR follows load at any time. The working copy of
  // the instruction is taken on the edge that leaves DECODE. Every later
  // step reads its register numbers and immediate from that copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir     <= '0;
      cur    <= '0;
      reg_a  <= '0;
      reg_b  <= '0;
      reg_c  <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (load) ir <= in;
      case (state)
        ST_DECODE: begin
          cur <= ir;
          if (ir_cls == CLS_MOV_REG || ir_cls == CLS_MVN) reg_a <= '0;
        end
        ST_GET_A: reg_a <= regs[cur_rn];
        ST_GET_B: reg_b <= regs[cur_rm];
        ST_CALC: begin
          reg_c <= alu_res;
          if (cur_cls == CLS_CMP) begin
            flag_z <= (diff == '0);
            flag_n <= diff[WIDTH-1];
            flag_v <= diff_v;
          end
        end
        ST_WRITE_REG: regs[cur_rd] <= reg_c;
        ST_WRITE_IMM: regs[cur_rn] <= imm_ext;
        default: ;
      endcase
    end
  end

  assign w   = (state == ST_WAIT);
  assign out = reg_c;
  assign Z   = flag_z;
  assign N   = flag_n;
  assign V   = flag_v;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Testbench for datapath_ctrl. A table of instructions with hand-derived
// results runs against a WIDTH=16 instance. A WIDTH=32 instance receives the
// same stimulus and is checked where sign extension matters. Hand-written
// sequences cover reset during CALC and back-to-back starts with s held high.
module tb_datapath_ctrl;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   in;
  logic          load;
  logic          s;
  logic          w, z, n, v, err;
  logic [W-1:0]  out;
  logic          w32, z32, n32, v32, err32;
  logic [31:0]   out32;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [15:0] instr;
    logic [W-1:0] exp_out;
    logic [2:0]  exp_znv;
    int          exp_lat;
    int          exp_err;
    logic        chk32;
    logic [31:0] exp_out32;
  } vec_t;

  vec_t vecs[$];

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  datapath_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s),
    .w(w), .out(out), .Z(z), .N(n), .V(v), .err(err)
  );

  datapath_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s),
    .w(w32), .out(out32), .Z(z32), .N(n32), .V(v32), .err(err32)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc_imm(input logic [2:0] rn, input logic [7:0] im);
    return {3'b110, 2'b10, rn, im};
  endfunction

  function automatic logic [15:0] enc_alu(input logic [2:0] opc, input logic [1:0] op,
                                          input logic [2:0] rn, input logic [2:0] rd,
                                          input logic [1:0] sh, input logic [2:0] rm);
    return {opc, op, rn, rd, sh, rm};
  endfunction

  function automatic vec_t mk(input logic [15:0] i, input logic [W-1:0] o,
                              input logic [2:0] znv, input int lat, input int e,
                              input logic c32, input logic [31:0] o32);
    vec_t t;
    t.instr = i; t.exp_out = o; t.exp_znv = znv; t.exp_lat = lat;
    t.exp_err = e; t.chk32 = c32; t.exp_out32 = o32;
    return t;
  endfunction

  // Driver: wait for ready, load IR, pulse s for one edge. Then count edges
  // from the s-sampling edge until w returns, and count err-high cycles.
  task automatic run_instr(input logic [15:0] instr, output int lat, output int errs);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!w && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in = instr; load = 1'b1; s = 1'b0;
    @(negedge clk);
    load = 1'b0; s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s = 1'b0;
    lat  = 1;
    errs = err ? 1 : 0;
    while (!w && lat < 20) begin
      @(negedge clk);
      lat++;
      if (err) errs++;
    end
  endtask

  initial begin
    int lat, errs;
    logic [W-1:0] exp;

    // MOV R0,#7 ; MOV R1,#2 ; ADD R2,R1,R0,LSL#1 ; read R2
    vecs.push_back(mk(enc_imm(3'd0, 8'h07), 16'h0000, 3'b000, 3, 0, 1'b0, 32'h0));
    vecs.push_back(mk(enc_imm(3'd1, 8'h02), 16'h0000, 3'b000, 3, 0, 1'b0, 32'h0));
    vecs.push_back(mk(enc_alu(3'b101, 2'b00, 3'd1, 3'd2, 2'b01, 3'd0), 16'h0010, 3'b000, 6, 0, 1'b0, 32'h0));
    vecs.push_back(mk(enc_alu(3'b110, 2'b00, 3'd0, 3'd3, 2'b00, 3'd2), 16'h0010, 3'b000, 5, 0, 1'b0, 32'h0));
    // MOV R0,#-1 ; read R0 at both widths ; CMP R0,R0
    vecs.push_back(mk(enc_imm(3'd0, 8'hFF), 16'h0010, 3'b000, 3, 0, 1'b1, 32'h0000_0010));
    vecs.push_back(mk(enc_alu(3'b110, 2'b00, 3'd0, 3'd0, 2'b00, 3'd0), 16'hFFFF, 3'b000, 5, 0, 1'b1, 32'hFFFF_FFFF));
    vecs.push_back(mk(enc_alu(3'b101, 2'b01, 3'd0, 3'd0, 2'b00, 3'd0), 16'h0000, 3'b100, 5, 0, 1'b0, 32'h0));
    // MOV R4,#-128 then eight MOV R4,R4,LSL#1
    vecs.push_back(mk(enc_imm(3'd4, 8'h80), 16'h0000, 3'b100, 3, 0, 1'b1, 32'h0));
    vecs.push_back(mk(enc_alu(3'b110, 2'b00, 3'd0, 3'd4, 2'b01, 3'd4), 16'hFF00, 3'b100, 5, 0, 1'b1, 32'hFFFF_FF00));
    vecs.push_back(mk(enc_alu(3'b110, 2'b00, 3'd0, 3'd4, 2'b01, 3'd4), 16'hFE00, 3'b100, 5, 0, 1'b0, 32'h0));
    vecs.push_back(mk(enc_alu(3'b110, 2'b00, 3'd0, 3'd4, 2'b01, 3'd4), 16'hFC00, 3'b100, 5, 0, 1'b0, 32'h0));
    vecs.push_back(mk(enc_alu(3'b110, 2'b00, 3'd0, 3'd4, 2'b01, 3'd4), 16'hF800, 3'b100, 5, 0, 1'b0, 32'h0));
    vecs.push_back(mk(enc_alu(3'b110, 2'b00, 3'd0, 3'd4, 2'b01, 3'd4), 16'hF000, 3'b100, 5, 0, 1'b0, 32'h0));
    vecs.push_back(mk(enc_alu(3'b110, 2'b00, 3'd0, 3'd4, 2'b01, 3'd4), 16'hE000, 3'b100, 5, 0, 1'b0, 32'h0));
    vecs.push_back(mk(enc_alu(3'b110, 2'b00, 3'd0, 3'd4, 2'b01, 3'd4), 16'hC000, 3'b100, 5, 0, 1'b0, 32'h0));
    vecs.push_back(mk(enc_alu(3'b110, 2'b00, 3'd0, 3'd4, 2'b01, 3'd4), 16'h8000, 3'b100, 5, 0, 1'b0, 32'h0));
    // MOV R5,#1 ; CMP R4,R5 overflows ; R4 and R5 unchanged
    vecs.push_back(mk(enc_imm(3'd5, 8'h01), 16'h8000, 3'b100, 3, 0, 1'b0, 32'h0));
    vecs.push_back(mk(enc_alu(3'b101, 2'b01, 3'd4, 3'd0, 2'b00, 3'd5), 16'h7FFF, 3'b001, 5, 0, 1'b0, 32'h0));
    vecs.push_back(mk(enc_alu(3'b110, 2'b00, 3'd0, 3'd6, 2'b00, 3'd4), 16'h8000, 3'b001, 5, 0, 1'b0, 32'h0));
    vecs.push_back(mk(enc_alu(3'b110, 2'b00, 3'd0, 3'd6, 2'b00, 3'd5), 16'h0001, 3'b001, 5, 0, 1'b0, 32'h0));
    // MVN, AND with ASR, LSR, ADD wrap, ASR of a negative value
    vecs.push_back(mk(enc_alu(3'b101, 2'b11, 3'd0, 3'd7, 2'b00, 3'd5), 16'hFFFE, 3'b001, 5, 0, 1'b0, 32'h0));
    vecs.push_back(mk(enc_alu(3'b101, 2'b10, 3'd4, 3'd6, 2'b11, 3'd7), 16'h8000, 3'b001, 6, 0, 1'b0, 32'h0));
    vecs.push_back(mk(enc_alu(3'b110, 2'b00, 3'd0, 3'd6, 2'b10, 3'd4), 16'h4000, 3'b001, 5, 0, 1'b0, 32'h0));
    vecs.push_back(mk(enc_alu(3'b101, 2'b00, 3'd4, 3'd6, 2'b00, 3'd4), 16'h0000, 3'b001, 6, 0, 1'b0, 32'h0));
    vecs.push_back(mk(enc_alu(3'b110, 2'b00, 3'd0, 3'd6, 2'b11, 3'd7), 16'hFFFF, 3'b001, 5, 0, 1'b0, 32'h0));
    // Illegal opcodes: no write, C and flags unchanged
    vecs.push_back(mk(16'h0000, 16'hFFFF, 3'b001, 2, 1, 1'b0, 32'h0));
    vecs.push_back(mk(enc_alu(3'b101, 2'b11, 3'd0, 3'd7, 2'b00, 3'd5) & 16'h1FFF, 16'hFFFF, 3'b001, 2, 1, 1'b0, 32'h0));
    vecs.push_back(mk(16'hC800, 16'hFFFF, 3'b001, 2, 1, 1'b0, 32'h0));
    vecs.push_back(mk(enc_alu(3'b110, 2'b00, 3'd0, 3'd6, 2'b00, 3'd7), 16'hFFFE, 3'b001, 5, 0, 1'b0, 32'h0));

    // Reset and reset-state checks.
    reset = 1'b1; in = '0; load = 1'b0; s = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_w", w, 1'b1);
    check("rst_out", out, '0);
    check("rst_znv", {z, n, v}, 3'b000);
    check("rst_err", err, 1'b0);
    check("rst_out32", out32, 32'h0);
    reset = 1'b0;

    // Table-driven vectors. Expected out goes into the scoreboard at issue
    // and is compared when the instruction completes.
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp_out);
      run_instr(vecs[i].instr, lat, errs);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_err", i), errs, vecs[i].exp_err);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check($sformatf("v%0d_out", i), out, exp);
      end else begin
        check($sformatf("v%0d_sb_empty", i), 1'b1, 1'b0);
      end
      check($sformatf("v%0d_znv", i), {z, n, v}, vecs[i].exp_znv);
      if (vecs[i].chk32) check($sformatf("v%0d_out32", i), out32, vecs[i].exp_out32);
    end

    // Back-to-back MOV imm with s held high; IR reloaded while the first runs.
    @(negedge clk);
    in = enc_imm(3'd1, 8'h03); load = 1'b1;
    @(negedge clk);
    load = 1'b0; s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in = enc_imm(3'd2, 8'h04); load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("b2b_first_busy", w, 1'b0);
    @(negedge clk);
    check("b2b_first_done", w, 1'b1);
    @(negedge clk);
    check("b2b_second_start", w, 1'b0);
    s = 1'b0;
    @(negedge clk);
    check("b2b_second_busy", w, 1'b0);
    @(negedge clk);
    check("b2b_second_done", w, 1'b1);
    run_instr(enc_alu(3'b110, 2'b00, 3'd0, 3'd1, 2'b00, 3'd1), lat, errs);
    check("b2b_r1", out, 16'h0003);
    run_instr(enc_alu(3'b110, 2'b00, 3'd0, 3'd2, 2'b00, 3'd2), lat, errs);
    check("b2b_r2", out, 16'h0004);

    // Reset during CALC of ADD R3,R3,R3 with R3=5.
    run_instr(enc_imm(3'd3, 8'h05), lat, errs);
    run_instr(enc_alu(3'b110, 2'b00, 3'd0, 3'd3, 2'b00, 3'd3), lat, errs);
    check("rc_r3_before", out, 16'h0005);
    @(negedge clk);
    in = enc_alu(3'b101, 2'b00, 3'd3, 3'd3, 2'b00, 3'd3); load = 1'b1;
    @(negedge clk);
    load = 1'b0; s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s = 1'b0;
    repeat (3) @(negedge clk);
    check("rc_in_calc", w, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("rc_w", w, 1'b1);
    check("rc_out", out, 16'h0000);
    check("rc_znv", {z, n, v}, 3'b000);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rc_idle", w, 1'b1);
    check("rc_out_idle", out, 16'h0000);
    run_instr(enc_alu(3'b110, 2'b00, 3'd0, 3'd3, 2'b00, 3'd3), lat, errs);
    check("rc_r3_after", out, 16'h0000);
    check("rc_r3_lat", lat, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_ctrl.md
DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the datapath word width; legal range is 16 to 64.
REQ-002 Port clk SHALL be an input, 1 bit wide, and serve as the single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit wide, and act as a synchronous, active-high reset.
REQ-004 Port in SHALL be an input, 16 bits wide, carrying the instruction word.
REQ-005 Port load SHALL be an input, 1 bit wide; when 1, in is captured into the instruction register (IR) at the edge.
REQ-006 Port s SHALL be an input, 1 bit wide, acting as the start request.
REQ-007 Port w SHALL be an output, 1 bit wide, equal to 1 exactly when the FSM is in WAIT (ready).
REQ-008 Port out SHALL be an output, WIDTH bits wide, carrying the contents of register C.
REQ-009 Ports Z, N and V SHALL be outputs, 1 bit wide each, carrying the registered status flags.
REQ-010 Port err SHALL be an output, 1 bit wide, pulsing for one cycle on an illegal opcode.

Function
REQ-011 The IR SHALL decode as opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0] and im8[7:0]; the block SHALL contain 8 registers, R0-R7, each WIDTH bits wide.
REQ-012 The legal instructions SHALL be: 110/10 MOV Rn,#im8; 110/00 MOV Rd,Rm{sh}; 101/00 ADD Rd,Rn,Rm{sh}; 101/01 CMP Rn,Rm{sh}; 101/10 AND; 101/11 MVN Rd,Rm{sh}; every other opcode/op combination is illegal.
REQ-013 im8 SHALL be sign-extended to WIDTH bits.
REQ-014 The shifter SHALL apply sh to operand B only: 00 none, 01 LSL by 1 (fill 0), 10 LSR by 1 (fill 0), 11 ASR by 1 (fill MSB).
REQ-015 The FSM SHALL have the states WAIT, DECODE, GET_A, GET_B, CALC, WRITE_REG, WRITE_IMM.
REQ-016 In WAIT, s=1 SHALL move the FSM to DECODE; s SHALL be ignored in all other states.
REQ-017 The path for MOV imm SHALL be DECODE->WRITE_IMM->WAIT, with Rn written on the edge leaving WRITE_IMM.
REQ-018 The path for MOV reg and MVN SHALL be DECODE->GET_B->CALC->WRITE_REG->WAIT, with A forced to 0.
REQ-019 The path for ADD and AND SHALL be DECODE->GET_A->GET_B->CALC->WRITE_REG->WAIT.
REQ-020 The path for CMP SHALL be DECODE->GET_A->GET_B->CALC->WAIT, with no register write.
REQ-021 GET_A SHALL load A from Rn, and GET_B SHALL load B from Rm.
REQ-022 CALC SHALL load C with the ALU result (ADD: A+B mod 2^WIDTH; CMP: A-B; AND: A&B; MVN: ~B).
REQ-023 WRITE_REG SHALL write C into Rd.
REQ-024 Z, N and V SHALL update only on the CALC edge of CMP: Z=(A-B==0), N=MSB of (A-B), V=signed overflow of A-B.
REQ-025 For an illegal opcode, DECODE SHALL go to WAIT, err SHALL be 1 for that DECODE cycle, and there SHALL be no write and no change to C or the flags.
REQ-026 With s held at 1, a new instruction SHALL start on the first edge spent in WAIT.
REQ-027 load asserted mid-instruction SHALL update IR, but the current instruction SHALL use the opcode/register fields latched at DECODE.
REQ-028 Latency from the edge that samples s to w=1 SHALL be: MOV imm 3 edges, MOV reg/MVN/CMP 5 edges, ADD/AND 6 edges, illegal 2 edges.

Reset
REQ-029 On reset, the FSM SHALL go to WAIT (w=1), IR, A, B and C SHALL be cleared to 0 (out=0), R0-R7 SHALL be cleared to 0, Z/N/V SHALL be cleared to 0, and err SHALL be 0.
REQ-030 Reset in any state SHALL abort the instruction with no register write, and reset SHALL take priority over s and load.

Verification
REQ-031 MOV R0,#7; MOV R1,#2; ADD R2,R1,R0,LSL#1 -> R2=out=0x0010, w=1 exactly 6 edges after the ADD start, and flags unchanged.
REQ-032 MOV R0,#-1 at WIDTH=16 and WIDTH=32 -> R0=0xFFFF and 0xFFFFFFFF respectively; CMP R0,R0 -> Z=1, N=0, V=0.
REQ-033 MOV R4,#-128, then eight MOV R4,R4,LSL#1 (R4=0x8000), MOV R5,#1, CMP R4,R5 -> Z=0, N=0, V=1, and R4/R5 unchanged.
REQ-034 Reset asserted during CALC of an ADD into R3 (R3=0x0005 beforehand) -> next cycle w=1, out=0, R3=0, and no later write to R3.
REQ-035 in=0x0000 plus s=1 -> err=1 for one cycle, w=1 after 2 edges, and registers/flags unchanged; then s held high across two back-to-back MOV imm -> both complete, 3 edges each.
